ppu_issue_stage: RTL and testbench

Sequential front-end that owns the handshake around the combinational posit arithmetic core (p1/p2/op in, pout out).
- Buffers incoming operation requests in a small FIFO.
- Registers operands onto the core inputs (stage A) and captures the core result into an output register (stage B).
- Presents results downstream over a valid/ready interface with a request tag and NaR status.
- Turns the purely combinational core into a 1-op/cycle, 2-register pipeline.

---
 rtl/ppu_issue_stage_pkg.sv | 22 ++
 rtl/ppu_req_fifo.sv | 70 +++++++
 rtl/ppu_issue_stage.sv | 193 +++++++++++++++++++
 tb/tb_ppu_issue_stage.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_issue_stage_pkg.sv
// ppu_issue_stage_pkg
//   Definitions shared by the posit issue stage and its request FIFO:
//   the op field width, the op encodings understood by the arithmetic core,
//   and a helper that builds the NaR bit pattern for a given posit width.
package ppu_issue_stage_pkg;

  localparam int OP_SIZE = 2;

  typedef enum logic [OP_SIZE-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  // NaR is a single 1 in the sign position followed by zeros.
  // Callers truncate the result to their posit width.
  function automatic logic [63:0] nar_pattern(input int unsigned n);
    nar_pattern = 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/ppu_req_fifo.sv
// ppu_req_fifo
//   Small synchronous FIFO holding pending operation requests.
//   The head entry is read combinationally from the storage array, so an
//   entry written on one edge is visible at pop_data from the next cycle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_data     write request (ignored while full)
//   pop                 remove head entry (ignored while empty)
//   pop_data            current head entry
//   full, empty, count  occupancy status, count in 0..DEPTH
module ppu_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  logic do_push;
  logic do_pop;

  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign pop_data = mem[rd_ptr_reg];

  // A full FIFO refuses a push even when a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset; reset discards contents by clearing count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ppu_issue_stage.sv
// ppu_issue_stage
//   Sequential wrapper around the combinational posit arithmetic core.
//   Requests are queued in a FIFO, registered onto the core inputs
//   (stage A), and the core result is captured into an output register
//   (stage B) presented over valid/ready. One op per cycle, in order.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   in_valid/in_ready                 request handshake
//   in_p1, in_p2, in_op, in_tag       request operands, op code and user tag
//   core_p1, core_p2, core_op         registered operands to the core
//   core_pout                         combinational core result
//   out_valid/out_ready               result handshake
//   out_pout, out_tag, out_nar        result, its tag, result-is-NaR flag
//   nar_sticky, nar_clear             sticky NaR flag and its clear
//   busy                              any request queued or in flight
//   ops_done                          completed output handshakes (wraps)
module ppu_issue_stage
  import ppu_issue_stage_pkg::*;
#(
  parameter int N     = 16,
  parameter int ES    = 1,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_p1,
  input  logic [N-1:0]       in_p2,
  input  logic [OP_SIZE-1:0] in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic [N-1:0]       core_p1,
  output logic [N-1:0]       core_p2,
  output logic [OP_SIZE-1:0] core_op,
  input  logic [N-1:0]       core_pout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_pout,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_nar,
  output logic               nar_sticky,
  input  logic               nar_clear,
  output logic               busy,
  output logic [CNT_W-1:0]   ops_done
);

  localparam logic [N-1:0] NAR = N'(nar_pattern(N));
  localparam int REQ_W = 2 * N + OP_SIZE + TAG_W;

  // Elaboration-time guard: an illegal parameter set instantiates a module
  // that does not exist, stopping the build. ES is otherwise only carried
  // through for consistency with the core.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ES >= N) begin : g_param_check
    illegal_ppu_issue_stage_parameters u_bad ();
  end

  // FIFO interface
  logic                   fifo_push;
  logic                   fifo_pop;
  logic [REQ_W-1:0]       fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  // Pipeline state
  logic               rdy_q;
  logic               a_valid_reg;
  logic [N-1:0]       a_p1_reg;
  logic [N-1:0]       a_p2_reg;
  logic [OP_SIZE-1:0] a_op_reg;
  logic [TAG_W-1:0]   a_tag_reg;
  logic               b_valid_reg;
  logic [N-1:0]       b_pout_reg;
  logic [TAG_W-1:0]   b_tag_reg;
  logic               b_nar_reg;
  logic               nar_sticky_reg;
  logic [CNT_W-1:0]   ops_done_reg;

  logic a_advance;
  logic a_load;
  logic core_is_nar;
  logic out_fire;

  // Head entry fields
  logic [N-1:0]       head_p1;
  logic [N-1:0]       head_p2;
  logic [OP_SIZE-1:0] head_op;
  logic [TAG_W-1:0]   head_tag;

  assign {head_p1, head_p2, head_op, head_tag} = fifo_head;

  // rdy_q keeps in_ready low through reset and the first edge after it.
  assign in_ready  = rdy_q && !fifo_full;
  assign fifo_push = in_valid && in_ready;

  // A moves into B whenever B is empty or B is being drained this cycle.
  assign a_advance   = a_valid_reg && (!b_valid_reg || out_ready);
  assign a_load      = !fifo_empty && (!a_valid_reg || a_advance);
  assign fifo_pop    = a_load;
  assign core_is_nar = (core_pout == NAR);
  assign out_fire    = b_valid_reg && out_ready;

  ppu_req_fifo #(
    .DEPTH (DEPTH),
    .W     (REQ_W)
  ) u_req_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({in_p1, in_p2, in_op, in_tag}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
    end
  end

  // Stage A: operand register feeding the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_reg <= 1'b0;
      a_p1_reg    <= '0;
      a_p2_reg    <= '0;
      a_op_reg    <= '0;
      a_tag_reg   <= '0;
    end else if (a_load) begin
      a_valid_reg <= 1'b1;
      a_p1_reg    <= head_p1;
      a_p2_reg    <= head_p2;
      a_op_reg    <= head_op;
      a_tag_reg   <= head_tag;
    end else if (a_advance) begin
      // Operands are left in place so the core inputs stay quiet.
      a_valid_reg <= 1'b0;
    end
  end

  // Stage B: result register; holds steady while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid_reg <= 1'b0;
      b_pout_reg  <= '0;
      b_tag_reg   <= '0;
      b_nar_reg   <= 1'b0;
    end else if (a_advance) begin
      b_valid_reg <= 1'b1;
      b_pout_reg  <= core_pout;
      b_tag_reg   <= a_tag_reg;
      b_nar_reg   <= core_is_nar;
    end else if (out_ready) begin
      b_valid_reg <= 1'b0;
    end
  end

  // A new NaR capture takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nar_sticky_reg <= 1'b0;
      ops_done_reg   <= '0;
    end else begin
      if (a_advance && core_is_nar) begin
        nar_sticky_reg <= 1'b1;
      end else if (nar_clear) begin
        nar_sticky_reg <= 1'b0;
      end
      if (out_fire) begin
        ops_done_reg <= ops_done_reg + 1'b1;
      end
    end
  end

  assign core_p1    = a_p1_reg;
  assign core_p2    = a_p2_reg;
  assign core_op    = a_op_reg;
  assign out_valid  = b_valid_reg;
  assign out_pout   = b_pout_reg;
  assign out_tag    = b_tag_reg;
  assign out_nar    = b_nar_reg;
  assign nar_sticky = nar_sticky_reg;
  assign ops_done   = ops_done_reg;
  assign busy       = (fifo_count != '0) || a_valid_reg || b_valid_reg;

endmodule

// File: tb/tb_ppu_issue_stage.sv
// tb_ppu_issue_stage
//   Directed bench for ppu_issue_stage with a behavioural core model and a
//   request scoreboard. Inputs change 1 time unit after the rising edge;
//   handshakes and output stability are observed on the falling edge.
module tb_ppu_issue_stage;
  import ppu_issue_stage_pkg::*;

  localparam int N     = 16;
  localparam int TAG_W = 4;
  localparam int CNT_W = 16;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       in_p1;
  logic [N-1:0]       in_p2;
  logic [OP_SIZE-1:0] in_op;
  logic [TAG_W-1:0]   in_tag;
  logic [N-1:0]       core_p1;
  logic [N-1:0]       core_p2;
  logic [OP_SIZE-1:0] core_op;
  logic [N-1:0]       core_pout;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       out_pout;
  logic [TAG_W-1:0]   out_tag;
  logic               out_nar;
  logic               nar_sticky;
  logic               nar_clear;
  logic               busy;
  logic [CNT_W-1:0]   ops_done;

  typedef struct packed {
    logic [N-1:0]       p1;
    logic [N-1:0]       p2;
    logic [OP_SIZE-1:0] op;
    logic [TAG_W-1:0]   tag;
  } req_t;

  req_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   accepted = 0;
  int   results  = 0;

  logic             hold_flag = 1'b0;
  logic [N-1:0]     held_pout;
  logic [TAG_W-1:0] held_tag;

  ppu_issue_stage #(
    .N(N), .ES(1), .DEPTH(4), .TAG_W(TAG_W), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_p1      (in_p1),
    .in_p2      (in_p2),
    .in_op      (in_op),
    .in_tag     (in_tag),
    .core_p1    (core_p1),
    .core_p2    (core_p2),
    .core_op    (core_op),
    .core_pout  (core_pout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pout   (out_pout),
    .out_tag    (out_tag),
    .out_nar    (out_nar),
    .nar_sticky (nar_sticky),
    .nar_clear  (nar_clear),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in core: NaR on NaR input or divide by zero, 1.0+1.0 = 2.0,
  // otherwise an order-sensitive mix of the operands.
  function automatic logic [N-1:0] model_core(input logic [N-1:0] a,
                                              input logic [N-1:0] b,
                                              input logic [OP_SIZE-1:0] op);
    if (a == 16'h8000 || b == 16'h8000) return 16'h8000;
    if (op == OP_DIV && b == 16'h0000) return 16'h8000;
    if (op == OP_ADD && a == 16'h4000 && b == 16'h4000) return 16'h5000;
    return (a ^ {b[7:0], b[15:8]}) + {14'h0, op} + 16'h0011;
  endfunction

  assign core_pout = model_core(core_p1, core_p2, core_op);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] p1, input logic [N-1:0] p2,
                       input logic [OP_SIZE-1:0] op, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    in_p1    = p1;
    in_p2    = p2;
    in_op    = op;
    in_tag   = tag;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  // Handshake monitor and scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_flag) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_pout", 32'(out_pout), 32'(held_pout));
        chk("hold_tag", 32'(out_tag), 32'(held_tag));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_result", 32'd1, 32'd0);
        end else begin
          req_t r;
          logic [N-1:0] e;
          r = sb.pop_front();
          e = model_core(r.p1, r.p2, r.op);
          chk("result_pout", 32'(out_pout), 32'(e));
          chk("result_tag", 32'(out_tag), 32'(r.tag));
          chk("result_nar", 32'(out_nar), 32'(e == 16'h8000));
        end
        results++;
        $display("RESULT tag=%0d pout=%h nar=%0d", out_tag, out_pout, out_nar);
      end
      if (in_valid && in_ready) begin
        sb.push_back('{p1: in_p1, p2: in_p2, op: in_op, tag: in_tag});
        accepted++;
      end
      hold_flag = out_valid && !out_ready;
      held_pout = out_pout;
      held_tag  = out_tag;
    end else begin
      hold_flag = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base_ops;
    int base_acc;
    int base_res;
    int gaps;

    // ---- 1: reset release, first op latency ----
    rst_n = 1'b0; nar_clear = 1'b0; out_ready = 1'b1;
    drive(16'h4000, 16'h4000, OP_ADD, 4'd3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ops_done", 32'(ops_done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_edge1", 32'(in_ready), 32'd0);
    step();                                   // edge 1: rdy_q rises
    chk("in_ready_after_edge1", 32'(in_ready), 32'd1);
    step();                                   // edge 2: request accepted
    in_valid = 1'b0;
    chk("accepted_edge2", 32'(accepted), 32'd1);
    chk("lat_t0_out_valid", 32'(out_valid), 32'd0);
    step();                                   // A loads
    chk("lat_t1_out_valid", 32'(out_valid), 32'd0);
    chk("lat_t1_core_p1", 32'(core_p1), 32'h4000);
    step();                                   // B loads
    chk("lat_t2_out_valid", 32'(out_valid), 32'd1);
    chk("lat_t2_out_pout", 32'(out_pout), 32'h5000);
    chk("lat_t2_out_tag", 32'(out_tag), 32'd3);
    step();
    chk("first_ops_done", 32'(ops_done), 32'd1);
    chk("first_busy", 32'(busy), 32'd0);
    chk("core_hold_p1", 32'(core_p1), 32'h4000);

    // ---- 2: backpressure fills FIFO + A + B ----
    out_ready = 1'b0;
    base_ops = int'(ops_done);
    base_acc = accepted;
    for (int i = 0; i < 8; i++) begin
      drive(16'h1000 + 16'(i * 16'h0123), 16'h0200 + 16'(i), OP_MUL, 4'(i));
      step();
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(accepted - base_acc), 32'd6);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_out_tag", 32'(out_tag), 32'd0);
    out_ready = 1'b1;
    wait_idle("bp_drain");
    chk("bp_ops_done", 32'(int'(ops_done) - base_ops), 32'd6);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // ---- 3: back-to-back stream ----
    base_res = results;
    gaps = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          drive(16'(i * 16'h0311 + 16'h0101), 16'(16'h0a00 - i), 2'(i), 4'(i));
          step();
        end
        in_valid = 1'b0;
      end
      begin
        int w = 0;
        @(negedge clk);
        while (!out_valid && w < 10) begin
          @(negedge clk);
          w++;
        end
        for (int i = 0; i < 20; i++) begin
          if (!out_valid) gaps++;
          @(negedge clk);
        end
      end
    join
    chk("stream_gaps", 32'(gaps), 32'd0);
    wait_idle("stream_drain");
    chk("stream_results", 32'(results - base_res), 32'd20);

    // ---- 4: NaR detection and sticky flag ----
    nar_clear = 1'b1;
    step();
    nar_clear = 1'b0;
    chk("nar_precleared", 32'(nar_sticky), 32'd0);
    drive(16'h4000, 16'h8000, OP_DIV, 4'd9);
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("nar_out_valid", 32'(out_valid), 32'd1);
    chk("nar_out_nar", 32'(out_nar), 32'd1);
    chk("nar_sticky_set", 32'(nar_sticky), 32'd1);
    step();
    drive(16'h3000, 16'h8000, OP_ADD, 4'd10);
    step();
    in_valid = 1'b0;
    step();
    nar_clear = 1'b1;
    step();                                   // capture and clear together
    nar_clear = 1'b0;
    chk("nar_set_wins", 32'(nar_sticky), 32'd1);
    chk("nar_out_nar2", 32'(out_nar), 32'd1);
    step();
    nar_clear = 1'b1;
    step();
    nar_clear = 1'b0;
    chk("nar_clear_alone", 32'(nar_sticky), 32'd0);
    wait_idle("nar_drain");

    // ---- 5: random backpressure against scoreboard ----
    base_acc = accepted;
    base_res = results;
    for (int i = 0; i < 60; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_p1     = 16'($urandom);
      in_p2     = 16'($urandom);
      in_op     = 2'($urandom_range(0, 3));
      in_tag    = 4'($urandom_range(0, 15));
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle("rand_drain");
    chk("rand_no_loss", 32'(results - base_res), 32'(accepted - base_acc));
    chk("rand_sb_empty", 32'(sb.size()), 32'd0);

    // ---- 6: reset with work in flight ----
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(16'h2000 + 16'(i), 16'h0300, OP_SUB, 4'(i + 4));
      step();
    end
    in_valid = 1'b0;
    step();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_ops_done", 32'(ops_done), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd0);
    sb.delete();
    base_res = results;
    step();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) step();
    chk("post_rst_no_stale", 32'(results - base_res), 32'd0);
    chk("post_rst_ops_done", 32'(ops_done), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
